// File: rtl/psg_write_scheduler.sv
// Round-robin scheduler turning (register, value) commands into SN76489
// write-port bytes, with atomic tone pairs and a queued mute-all sequence.
module psg_write_scheduler #(
    parameter int WE_CYCLES  = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [2:0] req_reg0,
    input  logic [2:0] req_reg1,
    input  logic [9:0] req_val0,
    input  logic [9:0] req_val1,
    input  logic       mute_req,
    output logic [7:0] psg_data,
    output logic       psg_we_n,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_GAP1, S_DATA, S_GAP2, S_MUTE
    } state_t;

    typedef enum logic [1:0] {M_ENTER, M_LOW, M_GAP} mph_t;

    localparam logic [15:0] WE_LAST  = 16'(WE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      r_state, w_state_n;
    mph_t        r_mph, w_mph_n;
    logic [1:0]  r_midx, w_midx_n, w_midx_inc;
    logic [15:0] r_cnt, w_cnt_n;
    logic        r_we_n, w_we_n_n;
    logic [7:0]  r_data, w_data_n;
    logic        r_tone;
    logic [7:0]  r_b2;
    logic        r_mute_pend;
    logic        r_ptr;

    logic        w_sel;
    logic        w_can_grant;
    logic        w_cap;
    logic        w_mute_clr;
    logic [2:0]  w_reg;
    logic [9:0]  w_val;
    logic        w_noise;
    logic        w_tone;
    logic [7:0]  w_b1;

    // Contention goes to the pointer; otherwise whoever is asking wins.
    assign w_sel = (req_valid == 2'b11) ? r_ptr : req_valid[1];
    assign w_can_grant = (r_state == S_IDLE) && !r_mute_pend && (|req_valid);
    assign req_ready = w_can_grant ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

    assign w_reg   = w_sel ? req_reg1 : req_reg0;
    assign w_val   = w_sel ? req_val1 : req_val0;
    assign w_noise = (w_reg == 3'b110);
    assign w_tone  = !w_reg[0] && !w_noise;
    assign w_b1    = w_noise ? {5'b11100, w_val[2:0]}
                             : {1'b1, w_reg, w_val[3:0]};

    assign w_midx_inc = r_midx + 2'd1;

    always_comb begin
        w_state_n  = r_state;
        w_mph_n    = r_mph;
        w_midx_n   = r_midx;
        w_cnt_n    = r_cnt + 16'd1;
        w_we_n_n   = r_we_n;
        w_data_n   = r_data;
        w_cap      = 1'b0;
        w_mute_clr = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (r_mute_pend) begin
                    w_state_n = S_MUTE;
                    w_mph_n   = M_ENTER;
                end else if (|req_valid) begin
                    w_cap     = 1'b1;
                    w_state_n = S_LATCH;
                    w_we_n_n  = 1'b0;
                    w_data_n  = w_b1;
                end else if (mute_req) begin
                    w_state_n = S_MUTE;
                    w_mph_n   = M_ENTER;
                end
            end
            S_LATCH: begin
                if (r_cnt == WE_LAST) begin
                    w_state_n = S_GAP1;
                    w_we_n_n  = 1'b1;
                    w_cnt_n   = '0;
                end
            end
            S_GAP1: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_n = '0;
                    if (r_tone) begin
                        w_state_n = S_DATA;
                        w_we_n_n  = 1'b0;
                        w_data_n  = r_b2;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == WE_LAST) begin
                    w_state_n = S_GAP2;
                    w_we_n_n  = 1'b1;
                    w_cnt_n   = '0;
                end
            end
            S_GAP2: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                end
            end
            S_MUTE: begin
                unique case (r_mph)
                    M_ENTER: begin
                        w_mph_n    = M_LOW;
                        w_midx_n   = 2'd0;
                        w_we_n_n   = 1'b0;
                        w_data_n   = 8'h9F;
                        w_cnt_n    = '0;
                        w_mute_clr = 1'b1;
                    end
                    M_LOW: begin
                        if (r_cnt == WE_LAST) begin
                            w_mph_n  = M_GAP;
                            w_we_n_n = 1'b1;
                            w_cnt_n  = '0;
                        end
                    end
                    M_GAP: begin
                        if (r_cnt == GAP_LAST) begin
                            w_cnt_n = '0;
                            if (r_midx == 2'd3) begin
                                w_state_n = S_IDLE;
                            end else begin
                                w_midx_n = w_midx_inc;
                                w_mph_n  = M_LOW;
                                w_we_n_n = 1'b0;
                                w_data_n = {1'b1, w_midx_inc, 5'b11111};
                            end
                        end
                    end
                    default: w_mph_n = M_ENTER;
                endcase
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mph       <= M_ENTER;
            r_midx      <= 2'd0;
            r_cnt       <= '0;
            r_we_n      <= 1'b1;
            r_data      <= 8'h00;
            r_tone      <= 1'b0;
            r_b2        <= 8'h00;
            r_mute_pend <= 1'b0;
            r_ptr       <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_mph   <= w_mph_n;
            r_midx  <= w_midx_n;
            r_cnt   <= w_cnt_n;
            r_we_n  <= w_we_n_n;
            r_data  <= w_data_n;
            // A new mute request wins over the clear so it re-arms the sequence.
            if (mute_req)
                r_mute_pend <= 1'b1;
            else if (w_mute_clr)
                r_mute_pend <= 1'b0;
            if (w_cap) begin
                r_tone <= w_tone;
                r_b2   <= {2'b00, w_val[9:4]};
                r_ptr  <= ~w_sel;
            end
        end
    end

    assign psg_data = r_data;
    assign psg_we_n = r_we_n;
    assign busy     = (r_state != S_IDLE) || r_mute_pend;

endmodule

// File: doc/psg_write_scheduler.md
# psg_write_scheduler

Sequences register writes into the SN76489-compatible PSG core over its byte-wide write port: `ui_in` data and active-low /WE on `uio_in[0]`. Two requesters submit abstract (register, value) commands; the block arbitrates between them round-robin and serialises each command into one or two PSG bytes. It keeps latch/data byte pairs atomic and provides a high-priority "mute all" sequence. It sits between the host/player logic and the PSG top.

## Interface
Parameters:
- `WE_CYCLES`, default 1: cycles `psg_we_n` is held low per byte (≥1).
- `GAP_CYCLES`, default 1: cycles `psg_we_n` is held high after each byte (≥1).

Ports:
- `clk`: in, 1. Single clock.
- `rst_n`: in, 1. Reset; asynchronous, active-low.
- `req_valid`: in, 2. Per-requester command valid.
- `req_ready`: out, 2. Per-requester accept. A transfer occurs when valid & ready.
- `req_reg0`, `req_reg1`: in, 3. PSG register index, in PSG encoding:
  - 000/010/100: tone 0/1/2 frequency.
  - 110: noise control.
  - xx1: attenuation for channel xx.
- `req_val0`, `req_val1`: in, 10. Value. Only the low 4 bits are used for attenuation, and only the low 3 bits for noise.
- `mute_req`: in, 1. Single-cycle pulse requesting all channels muted.
- `psg_data`: out, 8. Byte to the PSG data bus.
- `psg_we_n`: out, 1. Active-low write enable to the PSG.
- `busy`: out, 1. High whenever the state is not IDLE, or a mute is pending.

## Operation
- **Reset state.** `psg_we_n`=1, `psg_data`=8'h00, `req_ready`=0, `busy`=0, state IDLE, mute_pending=0, round-robin pointer favours requester 0.
- **FSM states:** IDLE, LATCH, GAP1, DATA, GAP2, MUTE.
- **Byte encoding:**
  - Tone (reg 000/010/100): latch byte {1,reg,val[3:0]}, then data byte {2'b00,val[9:4]}.
  - Noise (110): single byte {1,110,1'b0,val[2:0]}.
  - Attenuation (reg[0]=1): single byte {1,reg,val[3:0]}.
- **IDLE, priority order:**
  - If mute_pending: go to MUTE; `req_ready`=0.
  - Else if any `req_valid`: grant one requester by round-robin. `req_ready` is high for that requester only, combinationally, in this cycle. The command is captured and the state goes to LATCH. The pointer then favours the other requester.
  - Only one of the two requesters is ever ready in a given cycle.
- **LATCH:** `psg_data`=first byte, `psg_we_n`=0 for WE_CYCLES, then go to GAP1.
- **GAP1:** `psg_we_n`=1 for GAP_CYCLES. Next state is DATA if the command is a tone, else IDLE.
- **DATA:** `psg_data`=second byte, `psg_we_n`=0 for WE_CYCLES, then go to GAP2.
- **GAP2:** GAP_CYCLES with `psg_we_n`=1, then go to IDLE.
- **MUTE:**
  - Emits 8'h9F, 8'hBF, 8'hDF, 8'hFF in order, each as WE_CYCLES low followed by GAP_CYCLES high.
  - Clears mute_pending when the first byte starts; returns to IDLE after the 4th gap.
- **mute_req latching.** A `mute_req` arriving in any state sets mute_pending. It never interrupts a command in progress: a tone latch/data pair always completes first. A `mute_req` that arrives during MUTE re-arms mute_pending, and the sequence runs again.
- **`psg_data` stability.** `psg_data` is stable from the first low cycle of `psg_we_n` through the end of the following gap. It holds its last value in IDLE.
- **Repeated writes.** With WE_CYCLES>1 the PSG re-writes the same byte every low cycle. This is idempotent and is acceptable, including for noise restart.

## Timing
- Command accepted in cycle T:
  - `psg_we_n` is low in T+1 .. T+WE_CYCLES.
  - For a single byte, IDLE is reached at T+1+WE_CYCLES+GAP_CYCLES.
  - For a tone, IDLE is reached at T+1+2·(WE_CYCLES+GAP_CYCLES).
- A new command can be accepted in the first IDLE cycle, so back-to-back single-byte throughput is one byte per 1+WE_CYCLES+GAP_CYCLES cycles.
- `mute_req` in cycle T while IDLE: MUTE entered at T+1, first low cycle at T+2. The whole sequence is 4·(WE+GAP) cycles, plus one cycle to enter.
- Outputs are registered. `req_ready` is the only combinational output; it depends only on the state, `req_valid` and the pointer.
- Reset asserted mid-operation: `psg_we_n` goes to 1 and all state clears immediately (asynchronously). The partially sent tone pair is abandoned. Release is synchronous to `clk`.

## Test plan
- **Single attenuation.** Defaults; req0 reg=011 val=5. Expect `req_ready`[0] high for 1 cycle, then one `psg_we_n` low pulse with `psg_data`=8'hB5, then IDLE 3 cycles after accept.
- **Tone pair.** req1 reg=100 val=10'h2A7. Expect bytes 8'hC7 then 8'h2A, each with a 1-cycle low pulse separated by a 1-cycle gap. IDLE is reached 5 cycles after accept.
- **Round-robin.** Both requesters hold valid continuously with distinct attenuation commands. Grants alternate 0,1,0,1 starting with 0; no byte of a tone pair is interleaved.
- **Mute during tone.** `mute_req` pulses during LATCH of a tone write. Expect the tone data byte to complete, then 9F, BF, DF, FF, with `busy` high throughout and no requester granted until done.
- **Parameters.** WE_CYCLES=3, GAP_CYCLES=2, noise reg=110 val=3'b101. Expect `psg_data`=8'hE5 with `psg_we_n` low for exactly 3 cycles, then 2 high cycles, then IDLE.
- **Async reset.** Assert `rst_n` low between the latch and data bytes of a tone. Expect `psg_we_n`=1 and `psg_data`=00 without waiting for a clock edge. After release, the first grant goes to requester 0.
